// File: rtl/button_debounce_latch.sv
// rtl/button_debounce_latch.sv - synchronise, debounce and latch cw/acw button presses into a CPU status byte
module button_debounce_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bc,
  input  logic       bac,
  input  logic       button_read,
  output logic [7:0] button_op
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {bac, bc};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic                   deb;
    logic [CW-1:0]          cnt;
    logic                   s2;

    assign s2       = sync[SYNC_STAGES-1];
    // A press fires on the edge the counter would reach DEBOUNCE_CYCLES while rising.
    assign press[b] = s2 && !deb && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync <= '0;
        deb  <= 1'b0;
        cnt  <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[b]};
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  logic [7:0] base;
  logic [7:0] next_op;
  logic [4:0] sum;
  logic [1:0] new_dir;
  logic       both_ev;

  // A read clears first; events on the same edge land on the cleared value.
  always_comb begin
    base    = button_read ? 8'h00 : button_op;
    next_op = base;
    both_ev = press[0] & press[1];
    new_dir = press[0] ? 2'b01 : 2'b10;
    sum     = {1'b0, base[5:2]} + (both_ev ? 5'd2 : 5'd1);
    if (press != 2'b00) begin
      next_op[7]   = 1'b1;
      next_op[5:2] = (sum > 5'd15) ? 4'hF : sum[3:0];
      if (both_ev) begin
        next_op[6] = 1'b1;
      end else begin
        next_op[1:0] = new_dir;
        next_op[6]   = base[6] | ((base[1:0] != 2'b00) && (base[1:0] != new_dir));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      button_op <= 8'h00;
    end else begin
      button_op <= next_op;
    end
  end

endmodule

// File: doc/button_debounce_latch.md
Name: button_debounce_latch

Overview:
Input-port stage that conditions the two raw snake-control push-buttons, bc (clockwise) and bac (anticlockwise), for the CPU. The block synchronises and debounces each button, then detects press events. Press events accumulate in a sticky status byte, button_op, which the RAM I/O window presents to the CPU. A one-cycle button_read pulse from the CPU consumes and clears the pending status, so no press made between game ticks is lost.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive cycles the synchronised input must differ from the debounced state before that state flips; legal range 2..65535; counter width is $clog2(DEBOUNCE_CYCLES+1).
SYNC_STAGES, 2, synchroniser depth per button; fixed at 2 (other values illegal).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
bc  input  1  raw clockwise button, asynchronous, active-high, may bounce.
bac  input  1  raw anticlockwise button, asynchronous, active-high, may bounce.
button_read  input  1  one-cycle pulse from the CPU; consumes the pending status at this edge.
button_op  output  8  registered status byte read by the CPU.

Behaviour:
- Reset (async, active-high): all synchroniser flops, debounced states, debounce counters and button_op go to 0 immediately; they stay 0 while reset is high.
- Synchroniser: per button, 2 flops, s1 <= raw, s2 <= s1.
- Debounce, per button:
  - Counter clears whenever s2 == deb.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, deb <= s2 and the counter clears.
  - A level held at s2 for fewer than DEBOUNCE_CYCLES cycles is ignored.
- Press event: a deb transition 0->1 on a given edge; it is applied to button_op at that same edge. Release (1->0) generates no event.
- Latency: bc rises before sampling edge 1 and stays high. deb and button_op update at edge DEBOUNCE_CYCLES+2 (edge 6 for default), not earlier.
- button_op fields:
  - [1:0] last direction: 00 none, 01 cw, 10 acw; 11 is never produced.
  - [5:2] event count since last read, saturating at 15.
  - [6] both_seen: set if at least one cw and one acw event occurred since last read.
  - [7] valid: set if any event is pending.
- Event-only edge: dir <= the pressed button's code; count <= min(count+1, 15); valid <= 1; both_seen updated.
- Simultaneous cw and acw events on one edge:
  - dir unchanged (stays 00 if nothing was pending).
  - count <= min(count+2, 15); both_seen <= 1; valid <= 1.
- button_read high at an edge: button_op clears to 0 first; any event(s) occurring at that same edge are then applied to the cleared value. No event is lost or double-counted.
- button_read while nothing is pending: button_op stays 0 and there is no other effect.
- button_read held high for multiple cycles: clears on every such edge (the CPU must pulse it).
- Reset asserted mid-debounce: partially counted presses are discarded. After release, a button already held high is debounced afresh and produces exactly one event.
- No combinational path from any input to button_op.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with count=3 pending -> button_op==8'h00 immediately, before the next clk edge; it remains 0 for 10 cycles after release with buttons idle.
- Single press (D=4): bc held high from edge 1 -> button_op==8'h85 (valid, count=1, dir=01) after edge 6, and 8'h00 sampled after edge 5; holding bc for 100 cycles keeps it at 8'h85.
- Bounce reject/accept: bac high for exactly 3 cycles then low -> button_op stays 8'h00; bac high for exactly 4 cycles -> button_op==8'h86.
- Sequence and saturation: cw, acw, cw presses with no read -> 8'hCD (valid, both_seen, count=3, dir=01); 20 cw presses -> count saturates, button_op==8'hBD.
- Simultaneous press: bc and bac rise on the same cycle from idle -> button_op==8'hC8 (dir=00, count=2, both_seen=1).
- Read/event collision: count=2 pending; button_read pulses on the same edge that a new acw event lands -> button_op==8'h86 afterwards; a further button_read pulse -> 8'h00.
